// File: rtl/mem_arb_pkg.sv
// Shared types for the BRAM port-B arbiter: FSM state and read-owner tag.
package mem_arb_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HALT = 1'b1
  } arb_state_e;

  localparam int TAG_W = 2;

  typedef enum logic [TAG_W-1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_DBG  = 2'd2
  } owner_tag_e;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of LSU, loader and BRAM port-B signals around mem_arbiter.
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              cpu_req;
  logic [BE_W-1:0]   cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic [BE_W-1:0]   dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_halt;
  logic              halt_ack;

  logic [BE_W-1:0]   web;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dib;
  logic [DATA_W-1:0] dob;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
    input  dob,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata, halt_ack,
    output web, addrb, dib
  );

  // Requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
    output dob,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, halt_ack,
    input  web, addrb, dib
  );
endinterface

// File: rtl/mem_arb_wait_cnt.sv
// Saturating wait counter for a pending loader request; sat when count reaches MAX_WAIT.
module mem_arb_wait_cnt #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q >= CNT_W'(MAX_WAIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)             cnt_d = '0;
    else if (inc && !sat) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// LSU / loader arbiter for BRAM port B with read-owner tagging and halt mode.
// Optional MEM_ARB_STARVE_EN adds a loader anti-starvation counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_arbiter: MAX_WAIT must be >= 1");
  end

  typedef struct packed {
    logic [BE_W-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_e state_q, state_d;
  owner_tag_e tag_q, tag_d;
  logic       cpu_gnt, dbg_gnt;
  logic       force_dbg;
  req_t       cpu_r, dbg_r, port_r;

  assign cpu_r.we    = bus.cpu_we;
  assign cpu_r.addr  = bus.cpu_addr;
  assign cpu_r.wdata = bus.cpu_wdata;
  assign dbg_r.we    = bus.dbg_we;
  assign dbg_r.addr  = bus.dbg_addr;
  assign dbg_r.wdata = bus.dbg_wdata;

`ifdef MEM_ARB_STARVE_EN
  logic wait_sat;

  mem_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.dbg_req & ~dbg_gnt),
    .clr   (dbg_gnt | ~bus.dbg_req),
    .sat   (wait_sat)
  );

  assign force_dbg = wait_sat;
`else
  assign force_dbg = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ARB;
    else        state_q <= state_d;
  end

  // Next state: halt is level-driven in both directions
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARB:  if (bus.dbg_halt)  state_d = ST_HALT;
      ST_HALT: if (!bus.dbg_halt) state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Grant outputs
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (bus.cpu_req && !(bus.dbg_req && force_dbg)) cpu_gnt = 1'b1;
        else if (bus.dbg_req)                           dbg_gnt = 1'b1;
      end
      ST_HALT: dbg_gnt = bus.dbg_req;
      default: ;
    endcase
  end

  always_comb begin
    port_r = '0;
    if (cpu_gnt)      port_r = cpu_r;
    else if (dbg_gnt) port_r = dbg_r;
  end

  // Only reads earn a tag; the tag steers next cycle's dob to its owner
  always_comb begin
    tag_d = TAG_NONE;
    if (cpu_gnt && (bus.cpu_we == '0))      tag_d = TAG_CPU;
    else if (dbg_gnt && (bus.dbg_we == '0)) tag_d = TAG_DBG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= TAG_NONE;
    else        tag_q <= tag_d;
  end

  assign bus.web        = port_r.we;
  assign bus.addrb      = port_r.addr;
  assign bus.dib        = port_r.wdata;

  assign bus.cpu_stall  = (bus.cpu_req & ~cpu_gnt) | (state_q == ST_HALT);
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.halt_ack   = (state_q == ST_HALT);

  assign bus.cpu_rvalid = (tag_q == TAG_CPU);
  assign bus.dbg_rvalid = (tag_q == TAG_DBG);
  assign bus.cpu_rdata  = bus.dob;
  assign bus.dbg_rdata  = bus.dob;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read-data scoreboard plus per-cycle grant/drive checks.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // BRAM port B model: byte-enabled write, registered read-first
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.web[b]) mem[bus.addrb[9:2]][8*b +: 8] <= bus.dib[8*b +: 8];
    bus.dob <= mem[bus.addrb[9:2]];
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] dbg_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid must match the oldest expected read for that owner
  always @(negedge clk) begin
    if (bus.cpu_rvalid === 1'b1) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_rvalid_unexpected: got rdata %h expected no rvalid at %0t", bus.cpu_rdata, $time);
      end else begin
        logic [31:0] e;
        e = cpu_q.pop_front();
        if (bus.cpu_rdata !== e) begin
          errors++;
          $display("FAIL cpu_rdata: got %h expected %h at %0t", bus.cpu_rdata, e, $time);
        end
      end
    end
    if (bus.dbg_rvalid === 1'b1) begin
      checks++;
      if (dbg_q.size() == 0) begin
        errors++;
        $display("FAIL dbg_rvalid_unexpected: got rdata %h expected no rvalid at %0t", bus.dbg_rdata, $time);
      end else begin
        logic [31:0] e;
        e = dbg_q.pop_front();
        if (bus.dbg_rdata !== e) begin
          errors++;
          $display("FAIL dbg_rdata: got %h expected %h at %0t", bus.dbg_rdata, e, $time);
        end
      end
    end
  end

  task automatic drive(input logic cr, input logic [3:0] cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic h);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
    bus.dbg_halt = h;
  endtask

  // One cycle: drive just after the edge, return at the falling edge for checks
  task automatic step(input logic cr, input logic [3:0] cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                      input logic h);
    @(posedge clk); #1;
    drive(cr, cw, ca, cd, dr, dw, da, dd, h);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  logic dreq;
  logic egnt;

  initial begin
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_halt_ack",   32'(bus.halt_ack),   32'h0);
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'h0);
    chk("rst_cpu_stall",  32'(bus.cpu_stall),  32'h0);
    chk("rst_addrb",      bus.addrb,           32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Loader writes seed memory
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0);
    chk("ldw0_gnt",  32'(bus.dbg_gnt), 32'h1);
    chk("ldw0_web",  32'(bus.web),     32'hF);
    chk("ldw0_dib",  bus.dib,          32'hDEADBEEF);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h40, 32'h12345678, 1'b0);
    chk("ldw1_gnt",  32'(bus.dbg_gnt), 32'h1);
    chk("ldw1_web",  32'(bus.web),     32'hF);
    chk("ldw1_addr", bus.addrb,        32'h40);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
    chk("ldr_gnt",   32'(bus.dbg_gnt), 32'h1);
    chk("ldr_web",   32'(bus.web),     32'h0);
    dbg_q.push_back(32'h12345678);

    // CPU only: read, full write, partial write, read back
    step(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("cpur_stall", 32'(bus.cpu_stall), 32'h0);
    chk("cpur_addr",  bus.addrb,          32'h100);
    cpu_q.push_back(32'hDEADBEEF);
    step(1'b1, 4'hF, 32'h80, 32'h11223344, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("cpuw_web",   32'(bus.web),       32'hF);
    step(1'b1, 4'h3, 32'h80, 32'hAAAABBBB, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("cpuw_be",    32'(bus.web),       32'h3);
    chk("cpuw_dib",   bus.dib,            32'hAAAABBBB);
    step(1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    cpu_q.push_back(32'h1122BBBB);
    idle();
    chk("idle_addrb", bus.addrb, 32'h0);

    // Contention: both requesting every cycle
    dreq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'h0, 32'h100, 32'h0, dreq, 4'h0, 32'h40, 32'h0, 1'b0);
`ifdef MEM_ARB_STARVE_EN
      egnt = (i == 8);
`else
      egnt = 1'b0;
`endif
      chk($sformatf("cont%0d_dbg_gnt", i),   32'(bus.dbg_gnt),   32'(egnt));
      chk($sformatf("cont%0d_cpu_stall", i), 32'(bus.cpu_stall), 32'(egnt));
      if (egnt) begin
        dbg_q.push_back(32'h12345678);
        dreq = 1'b0;
      end else begin
        cpu_q.push_back(32'hDEADBEEF);
      end
    end
    if (dreq) begin
      // Loader finally served once the CPU goes idle
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
      chk("cpu_idle_dbg_gnt", 32'(bus.dbg_gnt), 32'h1);
      dbg_q.push_back(32'h12345678);
    end
    idle();

    // Halt with a CPU read granted in the entry cycle
    step(1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    chk("h0_stall",    32'(bus.cpu_stall), 32'h0);
    chk("h0_halt_ack", 32'(bus.halt_ack),  32'h0);
    cpu_q.push_back(32'h1122BBBB);
    step(1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    chk("h1_halt_ack", 32'(bus.halt_ack),   32'h1);
    chk("h1_stall",    32'(bus.cpu_stall),  32'h1);
    chk("h1_rvalid",   32'(bus.cpu_rvalid), 32'h1);
    chk("h1_addrb",    bus.addrb,           32'h0);
    step(1'b1, 4'h0, 32'h80, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b1);
    chk("h2_dbg_gnt",  32'(bus.dbg_gnt),   32'h1);
    chk("h2_stall",    32'(bus.cpu_stall), 32'h1);
    chk("h2_addrb",    bus.addrb,          32'h100);
    dbg_q.push_back(32'hDEADBEEF);
    step(1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("h3_halt_ack", 32'(bus.halt_ack),  32'h1);
    chk("h3_stall",    32'(bus.cpu_stall), 32'h1);
    step(1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("h4_halt_ack", 32'(bus.halt_ack),  32'h0);
    chk("h4_stall",    32'(bus.cpu_stall), 32'h0);
    chk("h4_addrb",    bus.addrb,          32'h80);
    cpu_q.push_back(32'h1122BBBB);
    idle();

    // Reset right after a loader read grant inside HALT
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0, 1'b1);
    chk("r_pre_gnt", 32'(bus.dbg_gnt), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("r_dbg_rvalid", 32'(bus.dbg_rvalid), 32'h0);
    chk("r_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    chk("r_halt_ack",   32'(bus.halt_ack),   32'h0);
    chk("r_cpu_stall",  32'(bus.cpu_stall),  32'h0);
    @(posedge clk); #1;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    idle();
    chk("r_post_halt_ack", 32'(bus.halt_ack), 32'h0);
    idle();

    chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing BRAM data port B between the pipeline MEM stage (LSU) and the debug/program loader. It grants at most one access per cycle and tags each grant so the synchronous-read data is returned one cycle later to the right owner. It stalls the CPU when the CPU loses arbitration, and supports a full pipeline halt so the loader can own memory exclusively. It sits between the LSU/loader and the BRAM port B pins (`web`, `addrb`, `dib`, `dob`).

## Interface
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`.
- `MAX_WAIT`, 8, maximum cycles a pending loader request waits behind the CPU (≥1).

Ports:
- `clk  in  1  clock`
- `rst_n  in  1  reset. One clock; reset is asynchronous and active-low.`
- `cpu_req  in  1  MEM-stage access request (load or store)`
- `cpu_we  in  DATA_W/8  byte write enables; 0 means read`
- `cpu_addr  in  ADDR_W  byte address`
- `cpu_wdata  in  DATA_W  store data`
- `cpu_stall  out  1  CPU lost arbitration or is halted; pipeline must freeze`
- `cpu_rvalid  out  1  read data for the CPU is on `cpu_rdata``
- `cpu_rdata  out  DATA_W  read data (`dob` passthrough)`
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`: loader request, same widths and semantics as the `cpu_*` request ports.
- `dbg_gnt  out  1  loader access accepted this cycle`
- `dbg_rvalid  out  1  read data for the loader is on `dbg_rdata``
- `dbg_rdata  out  DATA_W  read data (`dob` passthrough)`
- `dbg_halt  in  1  loader requests exclusive ownership`
- `halt_ack  out  1  CPU is frozen and the loader owns the port`
- `web  out  DATA_W/8`; `addrb  out  ADDR_W`; `dib  out  DATA_W`: BRAM port B drive.
- `dob  in  DATA_W  BRAM port B read data, registered, valid one cycle after the address`

## Operation
- FSM states:
  - ARB: shared arbitration.
  - HALT: loader owns the port.
- Transitions:
  - ARB→HALT on a clock edge where `dbg_halt`=1.
  - HALT→ARB on a clock edge where `dbg_halt`=0.
- Grant in ARB (combinational, same cycle as request):
  - Only one requester: that requester is granted.
  - Both requesting: the CPU is granted, unless `wait_cnt` ≥ `MAX_WAIT` (then the loader is granted).
- Grant in HALT: the loader is granted whenever `dbg_req`=1; the CPU is never granted.
- `cpu_stall` = (`cpu_req` & ~cpu granted) | (state==HALT).
- `dbg_gnt` = loader granted.
- `halt_ack` = (state==HALT).
- Port drive:
  - Granted requester's `we`/`addr`/`wdata` go to `web`/`addrb`/`dib`.
  - No grant: `web`=0, `addrb`=0, `dib`=0.
- Read tag: a grant with `we`==0 registers owner tag {NONE, CPU, DBG}. On the next cycle the tagged owner's `rvalid`=1. Writes produce no `rvalid`.
- `wait_cnt`:
  - Increments on each cycle with `dbg_req` & ~`dbg_gnt`, saturating at `MAX_WAIT`.
  - Clears on `dbg_gnt`, or when `dbg_req`=0.
- Requester rules:
  - The CPU holds its request stable while `cpu_stall`=1.
  - The loader holds its request until `dbg_gnt`.

## Timing
- Reset values:
  - State ARB, `wait_cnt`=0, tag NONE.
  - `cpu_rvalid`=`dbg_rvalid`=`halt_ack`=0.
  - Combinational outputs follow their inputs with state at reset.
- Latency:
  - Grant: 0 cycles.
  - Read data: 1 cycle after grant.
  - Halt entry: `halt_ack` rises 1 cycle after `dbg_halt` is sampled.
  - Halt exit: `halt_ack` falls 1 cycle after `dbg_halt`=0 is sampled.
- A CPU read granted in the cycle the FSM enters HALT still returns `cpu_rvalid` the next cycle; no outstanding read is lost.
- Simultaneous requests with `wait_cnt`=`MAX_WAIT`: loader wins and the CPU stalls exactly 1 cycle.
- Asserting `rst_n` mid-transaction drops the tag: no `rvalid` follows, and HALT is exited.

## Configuration
- `MEM_ARB_STARVE_EN` defined: `wait_cnt` and the forced loader grant are present as described.
- Not defined: no counter; the CPU always wins in ARB. The loader is then served only on CPU-idle cycles or in HALT.

## Structure
- `mem_arb_pkg`:
  - State enum (ARB, HALT).
  - Owner tag enum (NONE, CPU, DBG).
  - Tag width constant.
- Sub-module `mem_arb_wait_cnt`: saturating counter with `inc`, `clr`, and `sat` output, parameterized by `MAX_WAIT`. Instantiated only under `MEM_ARB_STARVE_EN`.

## Test plan
- CPU only: read 0x100, BRAM word 0xDEADBEEF → `cpu_stall`=0; `cpu_rvalid`=1 with `cpu_rdata`=0xDEADBEEF next cycle.
- Loader only: write `dbg_we`=0xF, addr 0x40, data 0x12345678 → `dbg_gnt`=1, `web`=0xF, `addrb`=0x40; a loader read of 0x40 one cycle later returns 0x12345678.
- Contention with starvation enabled: both request continuously from cycle 0 → CPU granted cycles 0–7, loader granted cycle 8 with `cpu_stall`=1 in cycle 8 only; `wait_cnt` returns to 0.
- Contention with `MEM_ARB_STARVE_EN` undefined: 20 cycles of continuous CPU requests → `dbg_gnt` never asserts.
- Halt: `dbg_halt` at cycle 5 with a CPU read granted in cycle 5 → `cpu_rvalid` in cycle 6, `halt_ack`=1 from cycle 6, `cpu_stall`=1 throughout HALT; release → `halt_ack`=0 one cycle later.
- Reset in the cycle after a loader read grant → no `dbg_rvalid`; all registered outputs 0.
